// File: rtl/param_pingpong_buf.sv
// ---------------------------------------------------------------------------
// param_pingpong_buf
//
// Double-buffered (ping-pong) frame store between a wide word writer and a
// narrow lane reader. The writer fills bank cur_wr_buf while the reader drains
// the opposite bank. A writer commit swaps the banks, but only when the reader
// has released (or is releasing on the same edge) its bank. A commit against a
// still-busy read bank is refused and reported with a one-cycle overrun pulse.
// The writer then keeps overwriting the same bank.
//
// Parameters
//   WR_WIDTH     write word width (integer multiple of RD_WIDTH, ratio 2^n)
//   RD_WIDTH     read lane width
//   FRAME_WORDS  write words per bank (any value >= 1)
//   ENDIAN_SWAP  1: read lane 0 is the MSB lane of the written word
//                0: read lane 0 is the LSB lane of the written word
//
// Ports
//   clk          single clock, all registers on posedge
//   rst_n        asynchronous active-low reset
//   wr_data      write word
//   wr_addr      word address within the current write bank
//   wr_en        write strobe
//   wr_commit    frame complete, request bank swap
//   cur_wr_buf   bank index currently being written
//   rd_addr      lane address within the read bank
//   rd_data      registered read data (one cycle after rd_addr)
//   rd_avail     read bank holds a committed, unreleased frame
//   rd_release   reader has finished the read bank
//   overrun      one-cycle pulse: commit refused
//   overrun_cnt  saturating count of overrun pulses (optional, see below)
//
// Optional feature
//   PPBUF_OVERRUN_CNT_EN  when defined, adds the 8-bit overrun_cnt output.
//   It counts refused commits and saturates at 255. Only rst_n clears it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module param_pingpong_buf #(
  parameter int  WR_WIDTH    = 32,
  parameter int  RD_WIDTH    = 8,
  parameter int  FRAME_WORDS = 128,
  parameter int  ENDIAN_SWAP = 1,
  localparam int RATIO       = WR_WIDTH / RD_WIDTH,
  localparam int WA          = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1,
  localparam int RA          = (FRAME_WORDS * RATIO > 1) ? $clog2(FRAME_WORDS * RATIO) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WR_WIDTH-1:0] wr_data,
  input  logic [WA-1:0]       wr_addr,
  input  logic                wr_en,
  input  logic                wr_commit,
  output logic                cur_wr_buf,
  input  logic [RA-1:0]       rd_addr,
  output logic [RD_WIDTH-1:0] rd_data,
  output logic                rd_avail,
  input  logic                rd_release,
`ifdef PPBUF_OVERRUN_CNT_EN
  output logic [7:0]          overrun_cnt,
`endif
  output logic                overrun
);

  localparam int LOG2R = (RATIO > 1) ? $clog2(RATIO) : 0;

  // Elaboration-time sanity check on the width relationship
  if ((RATIO < 1) || ((WR_WIDTH % RD_WIDTH) != 0) || ((RATIO & (RATIO - 1)) != 0)) begin : g_param_check
    $error("param_pingpong_buf: WR_WIDTH must be a power-of-2 multiple of RD_WIDTH");
  end

  // Two banks of frame storage; contents are deliberately not reset
  logic [WR_WIDTH-1:0] bank_mem [2][FRAME_WORDS];

  logic                wr_in_range;
  logic                rd_bank;
  logic [RA-1:0]       rd_word;
  logic [RA-1:0]       rd_lane;
  logic [RA-1:0]       rd_phys_lane;
  logic                rd_in_range;
  logic [31:0]         rd_shift;
  logic [WR_WIDTH-1:0] rd_word_data;
  logic [RD_WIDTH-1:0] rd_data_next;

  logic busy;
  logic commit_ok;
  logic commit_refused;

  // Addresses beyond the frame (possible when FRAME_WORDS is not 2^n) are dropped
  assign wr_in_range = ({1'b0, wr_addr} < (WA + 1)'(FRAME_WORDS));

  // Writes always target the writer's bank. On a same-edge write+commit,
  // the old bank value of cur_wr_buf is used, so the final word lands in the
  // frame that is handed to the reader.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      bank_mem[cur_wr_buf][wr_addr] <= wr_data;
    end
  end

  // Lane address split: upper bits pick the word, low LOG2R bits pick the lane
  assign rd_bank      = ~cur_wr_buf;
  assign rd_word      = rd_addr >> LOG2R;
  assign rd_lane      = rd_addr & RA'(RATIO - 1);
  assign rd_in_range  = ({1'b0, rd_word} < (RA + 1)'(FRAME_WORDS));
  assign rd_phys_lane = (ENDIAN_SWAP != 0) ? (RA'(RATIO - 1) - rd_lane) : rd_lane;
  assign rd_shift     = 32'(rd_phys_lane) * 32'(RD_WIDTH);
  assign rd_word_data = bank_mem[rd_bank][rd_word[WA-1:0]];

  // Lane extraction; out-of-frame words read as zero
  always_comb begin
    rd_data_next = '0;
    if (rd_in_range) begin
      rd_data_next = RD_WIDTH'(rd_word_data >> rd_shift);
    end
  end

  // Registered read port: data appears one cycle after the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_data_next;
    end
  end

  // A release on the same edge frees the read bank for an incoming commit
  assign busy           = rd_avail & ~rd_release;
  assign commit_ok      = wr_commit & ~busy;
  assign commit_refused = wr_commit & busy;

  // Bank swap control. A successful commit always leaves rd_avail set, even
  // when it coincides with a release, because the newly committed frame is
  // immediately the reader's. A release without a commit empties the read side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_wr_buf <= 1'b0;
      rd_avail   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= commit_refused;
      if (commit_ok) begin
        cur_wr_buf <= ~cur_wr_buf;
        rd_avail   <= 1'b1;
      end else if (!wr_commit && rd_release) begin
        rd_avail   <= 1'b0;
      end
    end
  end

`ifdef PPBUF_OVERRUN_CNT_EN
  // Saturating overrun counter, incremented on the edge that raises overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= 8'd0;
    end else if (commit_refused && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`else
  // Overrun counter not built; overrun is reported by the pulse alone
`endif

endmodule
